// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-schedule round-constant sequencer.
//   - aes_mode_e    : key-size encoding carried on the mode input
//   - seq_state_e   : sequencer FSM states
//   - NK_*          : words per key (Nk) for each key size
//   - LAST_*        : index of the final expanded-key word for each key size
//   - XTIME_POLY    : reduction constant of GF(2^8) multiply-by-x
//   - RC_INIT       : first round constant
//   - mode_to_nk    : key-size encoding -> Nk
//   - nk_to_last    : Nk -> last word index
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128     = 2'd0,
        MODE_192     = 2'd1,
        MODE_256     = 2'd2,
        MODE_ILLEGAL = 2'd3
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [7:0] LAST_128 = 8'd43;
    localparam logic [7:0] LAST_192 = 8'd51;
    localparam logic [7:0] LAST_256 = 8'd59;

    localparam logic [7:0] XTIME_POLY = 8'h1B;
    localparam logic [7:0] RC_INIT    = 8'h01;

    // Illegal mode never reaches this: the FSM rejects it before latching.
    function automatic logic [3:0] mode_to_nk(input logic [1:0] mode);
        logic [3:0] nk;
        case (mode)
            MODE_192: nk = NK_192;
            MODE_256: nk = NK_256;
            default:  nk = NK_128;
        endcase
        return nk;
    endfunction

    function automatic logic [7:0] nk_to_last(input logic [3:0] nk);
        logic [7:0] last;
        case (nk)
            NK_192:  last = LAST_192;
            NK_256:  last = LAST_256;
            default: last = LAST_128;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// ---------------------------------------------------------------------------
// gf_xtime
// Combinational multiply-by-x in GF(2^8) with the AES polynomial.
// Ports:
//   i_a : 8-bit operand
//   o_y : (i_a << 1) ^ (i_a[7] ? 8'h1B : 8'h00)
// ---------------------------------------------------------------------------
module gf_xtime
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    logic [7:0] w_shifted;
    logic [7:0] w_reduce;

    assign w_shifted = {i_a[6:0], 1'b0};
    // The bit shifted out of the top folds back in as the reduction term.
    assign w_reduce  = i_a[7] ? XTIME_POLY : 8'h00;
    assign o_y       = w_shifted ^ w_reduce;

endmodule

// File: rtl/rcon_sequencer.sv
// ---------------------------------------------------------------------------
// rcon_sequencer
// Steps through the expanded-key word indices of an AES key schedule and,
// for each word i, tells the datapath whether to apply RotWord / SubWord to
// w[i-1] and which round constant to XOR in. Round constants are generated
// iteratively with xtime; there is no constant table.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_start      : start a sequence (only honoured in IDLE)
//   i_mode       : key size sampled with i_start (0=128, 1=192, 2=256, 3=illegal)
//   i_abort      : return to IDLE, highest priority
//   i_word_ready : sink accepts the presented word
//   o_valid      : o_word_idx / o_rcon / o_rot_en / o_sub_en are valid
//   o_word_idx   : index i of the word being produced
//   o_rcon       : {rc, zeros} on rotation words, zero otherwise
//   o_rot_en     : apply RotWord to w[i-1]
//   o_sub_en     : apply SubWord to w[i-1]
//   o_busy       : sequence in progress
//   o_done       : one-cycle pulse after the last word transfers
//   o_err        : one-cycle pulse after a start with the illegal mode
// ---------------------------------------------------------------------------
module rcon_sequencer
    import aes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic              i_abort,
    input  logic              i_word_ready,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_word_idx,
    output logic [WORD_W-1:0] o_rcon,
    output logic              o_rot_en,
    output logic              o_sub_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int PH_W = 3;

    // State registers
    seq_state_e        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [PH_W-1:0]   r_phase;
    logic [7:0]        r_rc;
    logic [3:0]        r_nk;
    logic              r_err;

    // Next-state wires
    seq_state_e        w_state_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic [PH_W-1:0]   w_phase_next;
    logic [7:0]        w_rc_next;
    logic [3:0]        w_nk_next;
    logic              w_err_next;

    // Decoded helpers
    logic              w_run;
    logic              w_phase0;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_phase_wrap;
    logic [3:0]        w_nk_sel;
    logic [7:0]        w_rc_xtime;

    gf_xtime u_gf_xtime (
        .i_a (r_rc),
        .o_y (w_rc_xtime)
    );

    assign w_run        = (r_state == ST_RUN);
    assign w_phase0     = (r_phase == '0);
    assign w_xfer       = w_run && i_word_ready;
    assign w_nk_sel     = mode_to_nk(i_mode);
    assign w_last_word  = (r_idx == IDX_W'(nk_to_last(r_nk)));
    // Phase tracks i mod Nk with a wrapping counter instead of a divider.
    assign w_phase_wrap = (r_phase == PH_W'(r_nk - 4'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_phase <= '0;
            r_rc    <= RC_INIT;
            r_nk    <= NK_128;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_phase <= w_phase_next;
            r_rc    <= w_rc_next;
            r_nk    <= w_nk_next;
            r_err   <= w_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_phase_next = r_phase;
        w_rc_next    = r_rc;
        w_nk_next    = r_nk;
        w_err_next   = 1'b0;

        if (i_abort) begin
            // Abort wins over start, transfer and DONE. A transfer presented
            // in the same cycle is still taken by the sink; we just stop.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_mode == MODE_ILLEGAL) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_nk_next    = w_nk_sel;
                            w_idx_next   = IDX_W'(w_nk_sel);
                            w_phase_next = '0;
                            w_rc_next    = RC_INIT;
                            w_state_next = ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_xfer) begin
                        if (w_last_word) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_idx_next   = r_idx + 1'b1;
                            w_phase_next = w_phase_wrap ? '0 : r_phase + 1'b1;
                            // rc advances once per rotation word consumed.
                            if (w_phase0) begin
                                w_rc_next = w_rc_xtime;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state so they hold steady
    // while the sink stalls.
    // ------------------------------------------------------------------
    assign o_valid    = w_run;
    assign o_busy     = w_run;
    assign o_word_idx = r_idx;
    assign o_rot_en   = w_run && w_phase0;
    // AES-256 has an extra SubWord-only step halfway through each key block.
    assign o_sub_en   = w_run && (w_phase0 || ((r_nk == NK_256) && (r_phase == PH_W'(4))));
    assign o_rcon     = (w_run && w_phase0) ? (WORD_W'(r_rc) << (WORD_W - 8)) : '0;
    // Abort suppresses the status pulses in the cycle it is seen.
    assign o_done     = (r_state == ST_DONE) && !i_abort;
    assign o_err      = r_err && !i_abort;

endmodule

// File: tb/tb_rcon_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rcon_sequencer
// Directed bench for rcon_sequencer: full sequences in all three key sizes,
// illegal mode, random sink stalls with start held high, abort and
// asynchronous reset in the middle of a sequence, each followed by a restart.
// ---------------------------------------------------------------------------
module tb_rcon_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_mode;
    logic        i_abort;
    logic        i_word_ready;
    logic        o_valid;
    logic [5:0]  o_word_idx;
    logic [31:0] o_rcon;
    logic        o_rot_en;
    logic        o_sub_en;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Known AES round constants, first ten.
    logic [7:0] rct [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    rcon_sequencer #(.WORD_W(32), .IDX_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_abort      (i_abort),
        .i_word_ready (i_word_ready),
        .o_valid      (o_valid),
        .o_word_idx   (o_word_idx),
        .o_rcon       (o_rcon),
        .o_rot_en     (o_rot_en),
        .o_sub_en     (o_sub_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(o_valid), 32'd0);
        chk({tag, " busy"},  32'(o_busy),  32'd0);
        chk({tag, " done"},  32'(o_done),  32'd0);
    endtask

    // One sequence. stop_at >= 0 interrupts at that index, with abort
    // (stop_abort=1) or with rst_n (stop_abort=0).
    task automatic run_seq(input logic [1:0] mode, input int nk, input int last,
                           input bit stalls, input bit noisy,
                           input int stop_at, input bit stop_abort);
        int          i;
        int          ph;
        int          cyc;
        int          xfers;
        bit          fin;
        bit          stopped;
        logic [31:0] exp_rcon;

        @(negedge clk);
        i_start      = 1'b1;
        i_mode       = mode;
        i_word_ready = 1'b1;
        @(negedge clk);
        if (noisy) i_mode = 2'd2;   // keep start high with another mode: must be ignored
        else       i_start = 1'b0;

        i = nk; cyc = 0; xfers = 0; fin = 1'b0; stopped = 1'b0;
        while (!fin && cyc < 600) begin
            ph       = i % nk;
            exp_rcon = (ph == 0) ? {rct[i / nk - 1], 24'h0} : 32'h0;
            chk("valid", 32'(o_valid),    32'd1);
            chk("busy",  32'(o_busy),     32'd1);
            chk("idx",   32'(o_word_idx), 32'(i));
            chk("rot",   32'(o_rot_en),   32'(ph == 0));
            chk("sub",   32'(o_sub_en),   32'((ph == 0) || (nk == 8 && ph == 4)));
            chk("rcon",  o_rcon,          exp_rcon);
            chk("done",  32'(o_done),     32'd0);
            i_word_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (i == stop_at) begin
                stopped = 1'b1;
                fin     = 1'b1;
                if (stop_abort) begin
                    i_abort      = 1'b1;
                    i_word_ready = 1'b1;
                    xfers++;
                    @(negedge clk);
                    i_abort = 1'b0;
                    chk_idle("abort");
                    @(negedge clk);
                    chk_idle("post-abort");
                end else begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle("rst");
                    chk("rst idx",  32'(o_word_idx), 32'd0);
                    chk("rst rcon", o_rcon,          32'd0);
                    chk("rst rot",  32'(o_rot_en),   32'd0);
                    chk("rst sub",  32'(o_sub_en),   32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk_idle("post-rst");
                end
            end else begin
                @(negedge clk);
                cyc++;
                if (i_word_ready) begin
                    xfers++;
                    if (i == last) fin = 1'b1;
                    else           i++;
                end
            end
        end
        chk("finished in budget", 32'(fin), 32'd1);

        if (fin && !stopped) begin
            i_start = 1'b0;
            i_mode  = 2'd0;
            chk("done pulse",  32'(o_done),  32'd1);
            chk("done valid",  32'(o_valid), 32'd0);
            chk("done busy",   32'(o_busy),  32'd0);
            chk("xfer count",  32'(xfers),   32'(last - nk + 1));
            @(negedge clk);
            chk_idle("after done");
        end
        i_word_ready = 1'b0;
        $display("sequence mode=%0d stalls=%0d stop_at=%0d: %0d transfers", mode, stalls, stop_at, xfers);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_mode       = 2'd0;
        i_abort      = 1'b0;
        i_word_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset err",  32'(o_err),      32'd0);
        chk("reset idx",  32'(o_word_idx), 32'd0);
        chk("reset rcon", o_rcon,          32'd0);
        chk("reset rot",  32'(o_rot_en),   32'd0);
        chk("reset sub",  32'(o_sub_en),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(2'd0, 4, 43, 1'b0, 1'b0, -1, 1'b0);
        run_seq(2'd1, 6, 51, 1'b0, 1'b0, -1, 1'b0);
        run_seq(2'd2, 8, 59, 1'b0, 1'b0, -1, 1'b0);

        // Illegal mode: one err cycle, never busy.
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'd3;
        @(negedge clk);
        i_start = 1'b0;
        i_mode  = 2'd0;
        chk("err pulse", 32'(o_err),  32'd1);
        chk("err busy",  32'(o_busy), 32'd0);
        @(negedge clk);
        chk("err clear", 32'(o_err),  32'd0);
        chk("err busy2", 32'(o_busy), 32'd0);
        $display("illegal mode start: err checked");
        run_seq(2'd0, 4, 43, 1'b0, 1'b0, -1, 1'b0);

        // Start together with abort in IDLE must not launch.
        @(negedge clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        chk_idle("start+abort");
        $display("start with abort in idle: ignored");

        run_seq(2'd0, 4, 43, 1'b1, 1'b1, -1, 1'b0);
        run_seq(2'd0, 4, 43, 1'b0, 1'b0, 20, 1'b1);
        run_seq(2'd0, 4, 43, 1'b0, 1'b0, -1, 1'b0);
        run_seq(2'd0, 4, 43, 1'b0, 1'b0, 20, 1'b0);
        run_seq(2'd0, 4, 43, 1'b0, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rcon_sequencer.md
RCON_SEQUENCER -- requirements
Module: rcon_sequencer

Interface
REQ-001 Parameter: WORD_W, default 32, width of the rcon output word; minimum 8.
REQ-002 Parameter: IDX_W, default 6, width of word_idx; minimum 6.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request a key-schedule sequence; sampled only in IDLE.
REQ-006 Port: mode  input  2  key size, sampled with start: 0=AES-128 (Nk=4), 1=AES-192 (Nk=6), 2=AES-256 (Nk=8), 3=illegal.
REQ-007 Port: abort  input  1  synchronous return to IDLE.
REQ-008 Port: word_ready  input  1  downstream accepts the current word.
REQ-009 Port: valid  output  1  word_idx, rcon, rot_en and sub_en are valid.
REQ-010 Port: word_idx  output  IDX_W  index i of the expanded-key word being produced.
REQ-011 Port: rcon  output  WORD_W  round constant, byte in the MSB lane, zeros elsewhere; all zero when unused.
REQ-012 Port: rot_en  output  1  apply RotWord to w[i-1].
REQ-013 Port: sub_en  output  1  apply SubWord to w[i-1].
REQ-014 Port: busy  output  1  high in RUN.
REQ-015 Port: done  output  1  one-cycle pulse after the last word transfers.
REQ-016 Port: err  output  1  one-cycle pulse on start with mode=3.

Function
REQ-017 FSM states: IDLE, RUN, DONE; reset state is IDLE.
REQ-018 IDLE + start + mode<3: latch Nk, set word_idx=Nk, phase=0, rc=8'h01, go to RUN next cycle.
REQ-019 IDLE + start + mode=3: err pulses on the next cycle; state stays IDLE; mode is not latched.
REQ-020 start outside IDLE is ignored.
REQ-021 RUN: valid=1; a transfer occurs on a cycle with valid and word_ready both high.
REQ-022 Phase counter tracks i mod Nk (0..Nk-1), incremented on each transfer and wrapping at Nk; no divider is used.
REQ-023 rot_en=1 when phase==0; otherwise rot_en=0.
REQ-024 sub_en=1 when phase==0, or when Nk==8 and phase==4; otherwise sub_en=0.
REQ-025 rcon = {rc, zeros} when phase==0; otherwise rcon=0.
REQ-026 On a transfer with phase==0, rc <= xtime(rc) = (rc<<1) XOR (rc[7] ? 8'h1B : 0), 8-bit result.
REQ-027 Outputs hold stable while valid && !word_ready.
REQ-028 The last word index is 43, 51 or 59 for Nk=4, 6 or 8 respectively.
REQ-029 A transfer of the last word moves the FSM to DONE; no further word is presented.
REQ-030 DONE lasts one cycle with done=1 and valid=0, then returns to IDLE.
REQ-031 abort has priority over all other events in any state: next state IDLE, done=0, err=0, no further transfer.
REQ-032 abort and a transfer in the same cycle: the transfer is counted by the sink, but the FSM still enters IDLE.
REQ-033 Latency: first valid occurs one cycle after start is accepted; there are no bubble cycles between transfers while word_ready is held high.

Reset
REQ-034 On rst_n low: state=IDLE, valid=0, busy=0, done=0, err=0, rot_en=0, sub_en=0, rcon=0, word_idx=0, phase=0, rc=8'h01, latched Nk=4.
REQ-035 Reset asserted mid-sequence discards all progress; the next start restarts the sequence from i=Nk.

Structure
REQ-036 Shared package aes_pkg holds the mode encoding enum, the Nk constants (4/6/8), the last-index constants (43/51/59), and the xtime polynomial 8'h1B.
REQ-037 One sub-module gf_xtime (8-bit combinational xtime) is instantiated for the rc update.
REQ-038 The block contains no lookup table of round constants; rc is generated iteratively.

Verification
REQ-039 Test: mode=0, word_ready=1 -> 40 transfers (i=4..43); rcon MSB sequence at i=4,8,..,40 is 01,02,04,08,10,20,40,80,1B,36; done pulses once.
REQ-040 Test: mode=1 -> 46 transfers (i=6..51); rot_en at i=6,12,..,48; final rcon 32'h80000000 at i=48; sub_en never high with phase!=0.
REQ-041 Test: mode=2 -> 52 transfers (i=8..59); sub_en with rot_en=0 and rcon=0 at i=12,20,..,52; final rcon 32'h40000000 at i=56.
REQ-042 Test: mode=3 with start -> err for exactly one cycle, busy stays 0; a following start with mode=0 runs normally.
REQ-043 Test: random word_ready stalls in mode=0 -> same 40-word sequence as REQ-039; outputs stable during every stall.
REQ-044 Test: abort at i=20, and separately rst_n low at i=20 -> IDLE, no done pulse; a restart yields i=4 with rcon 32'h01000000.
